// File: rtl/ber_pkg.sv
// ber_pkg: shared encodings and default widths for the BER sequencer, checkers and register blocks
// Contents: state_t (IDLE/CLEAR/MEASURE), default count/timer widths, idle value of the checker clear bus
package ber_pkg;
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_MEASURE} state_t;
   localparam int BER_CW = 58;
   localparam int BER_EW = 64;
   localparam int BER_TW = 32;
   // Every checker is held in clear while no channel is being measured.
   localparam logic [15:0] CLR_IDLE = '1;
endpackage

// File: rtl/ber_cnt_mux.sv
// ber_cnt_mux: NCH-way indexed select of packed per-channel receive/error counts
// Ports:
//   sel      - channel index
//   recv_all - packed receive counts, channel i at [i*CW +: CW]
//   err_all  - packed error counts, channel i at [i*EW +: EW]
//   recv/err - counts of the selected channel, 0 when sel >= NCH
module ber_cnt_mux
   import ber_pkg::*;
#(
   parameter int NCH = 7,
   parameter int CHW = 4,
   parameter int CW  = BER_CW,
   parameter int EW  = BER_EW
) (
   input  logic [CHW-1:0]    sel,
   input  logic [NCH*CW-1:0] recv_all,
   input  logic [NCH*EW-1:0] err_all,
   output logic [CW-1:0]     recv,
   output logic [EW-1:0]     err
);
   always_comb begin
      recv = '0;
      err  = '0;
      for (int i = 0; i < NCH; i++) begin
         recv = (sel == CHW'(i)) ? recv_all[i*CW +: CW] : recv;
         err  = (sel == CHW'(i)) ? err_all[i*EW +: EW] : err;
      end
   end
endmodule

// File: rtl/ber_seq_ctrl.sv
// ber_seq_ctrl: timed BER measurement sequencer over NCH per-channel PRBS checkers
// Ports:
//   CLK, RSTX           - clock, asynchronous active-low reset
//   START, CH_SEL       - run request (IDLE only) and channel index, latched on accept
//   WINDOW              - measured cycles (0 treated as 1), latched on accept
//   ABORT               - terminate the current run
//   ERR_LIMIT           - early-stop error threshold, 0 disables
//   CH_RECV_CNT/ERR_CNT - packed per-channel counts from the checkers
//   CH_CLR              - per-checker clear, 1 = clear
//   BUSY, DONE, ABORTED - run in progress, snapshot-valid pulse, abort pulse
//   LIMIT_HIT           - last run ended on ERR_LIMIT (sticky until next START)
//   RECV_CNT, ERR_CNT, ELAPSED - snapshot of the selected channel and measured cycles
// Build option: define BER_EARLY_STOP_EN to enable the ERR_LIMIT early stop;
// otherwise ERR_LIMIT is ignored and LIMIT_HIT stays 0.
module ber_seq_ctrl
   import ber_pkg::*;
#(
   parameter int NCH    = 7,
   parameter int CHW    = 4,
   parameter int CW     = BER_CW,
   parameter int EW     = BER_EW,
   parameter int TW     = BER_TW,
   parameter int SETTLE = 16
) (
   input  logic              CLK,
   input  logic              RSTX,
   input  logic              START,
   input  logic              ABORT,
   input  logic [CHW-1:0]    CH_SEL,
   input  logic [TW-1:0]     WINDOW,
   input  logic [EW-1:0]     ERR_LIMIT,
   input  logic [NCH*CW-1:0] CH_RECV_CNT,
   input  logic [NCH*EW-1:0] CH_ERR_CNT,
   output logic [NCH-1:0]    CH_CLR,
   output logic              BUSY,
   output logic              DONE,
   output logic              ABORTED,
   output logic              LIMIT_HIT,
   output logic [CW-1:0]     RECV_CNT,
   output logic [EW-1:0]     ERR_CNT,
   output logic [TW-1:0]     ELAPSED
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   state_t         state;
   logic [CHW-1:0] sel;
   logic [TW-1:0]  win;
   logic [TW-1:0]  timer;
   logic [TW-1:0]  elapsed;
   logic [SW-1:0]  settle;
   logic [CW-1:0]  recv_sel;
   logic [EW-1:0]  err_sel;
   logic           hit;
   logic           stop;
   ber_cnt_mux #(.NCH(NCH), .CHW(CHW), .CW(CW), .EW(EW)) u_mux (
      .sel      (sel),
      .recv_all (CH_RECV_CNT),
      .err_all  (CH_ERR_CNT),
      .recv     (recv_sel),
      .err      (err_sel)
   );
`ifdef BER_EARLY_STOP_EN
   logic [EW-1:0] limit;
   always_ff @(posedge CLK or negedge RSTX)
      if (!RSTX) limit <= '0;
      else if (state == S_IDLE && START) limit <= ERR_LIMIT;
   assign hit = (limit != '0) && (err_sel >= limit);
`else
   logic unused_err_limit;
   assign unused_err_limit = ^ERR_LIMIT;
   assign hit = 1'b0;
`endif
   assign stop = (timer == '0) || ABORT || hit;
   always_ff @(posedge CLK or negedge RSTX)
      if (!RSTX) begin
         state     <= S_IDLE;
         sel       <= '0;
         win       <= '0;
         timer     <= '0;
         elapsed   <= '0;
         settle    <= '0;
         CH_CLR    <= CLR_IDLE[NCH-1:0];
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ABORTED   <= 1'b0;
         LIMIT_HIT <= 1'b0;
         RECV_CNT  <= '0;
         ERR_CNT   <= '0;
         ELAPSED   <= '0;
      end else begin
         DONE    <= 1'b0;
         ABORTED <= 1'b0;
         case (state)
            S_IDLE:
               // Out-of-range channels are dropped silently; START beats ABORT here.
               if (START && 32'(CH_SEL) < NCH) begin
                  state     <= S_CLEAR;
                  sel       <= CH_SEL;
                  win       <= WINDOW;
                  settle    <= SW'(SETTLE - 1);
                  LIMIT_HIT <= 1'b0;
                  BUSY      <= 1'b1;
               end
            S_CLEAR:
               if (ABORT) begin
                  state   <= S_IDLE;
                  BUSY    <= 1'b0;
                  ABORTED <= 1'b1;
               end else if (settle == '0) begin
                  state   <= S_MEASURE;
                  timer   <= (win == '0) ? '0 : win - 1'b1;
                  elapsed <= '0;
                  CH_CLR  <= ~(NCH'(1) << sel);
               end else begin
                  settle <= settle - 1'b1;
               end
            S_MEASURE: begin
               timer   <= timer - 1'b1;
               elapsed <= elapsed + 1'b1;
               if (stop) begin
                  state     <= S_IDLE;
                  BUSY      <= 1'b0;
                  DONE      <= 1'b1;
                  ABORTED   <= ABORT;
                  LIMIT_HIT <= hit;
                  RECV_CNT  <= recv_sel;
                  ERR_CNT   <= err_sel;
                  // The current cycle is itself measured.
                  ELAPSED   <= elapsed + 1'b1;
                  CH_CLR    <= CLR_IDLE[NCH-1:0];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_ber_seq_ctrl.sv
// tb_ber_seq_ctrl: randomized scoreboard bench for ber_seq_ctrl against a cycle-count model
module tb_ber_seq_ctrl;
   localparam int NCH = 7;
   localparam int CHW = 4;
   localparam int CW = 58;
   localparam int EW = 64;
   localparam int TW = 32;
   localparam int SETTLE = 16;

   typedef struct {
      int cyc;
      int ch;
      bit done;
      bit aborted;
      bit lh;
      logic [CW-1:0] recv;
      logic [EW-1:0] err;
      logic [TW-1:0] el;
   } exp_t;

   logic CLK = 0, RSTX = 1, START = 0, ABORT = 0;
   logic [CHW-1:0] CH_SEL = '0;
   logic [TW-1:0] WINDOW = '0;
   logic [EW-1:0] ERR_LIMIT = '0;
   logic [NCH*CW-1:0] CH_RECV_CNT;
   logic [NCH*EW-1:0] CH_ERR_CNT;
   logic [NCH-1:0] CH_CLR;
   logic BUSY, DONE, ABORTED, LIMIT_HIT;
   logic [CW-1:0] RECV_CNT;
   logic [EW-1:0] ERR_CNT;
   logic [TW-1:0] ELAPSED;

   int tests = 0, fails = 0, cyc = 0, clr_cnt = 0;
   logic [NCH-1:0] clr_pat;
   exp_t q[$];
   logic [CW-1:0] snap_recv = '0;
   logic [EW-1:0] snap_err = '0;
   logic [TW-1:0] snap_el = '0;

   ber_seq_ctrl #(.NCH(NCH), .CHW(CHW), .CW(CW), .EW(EW), .TW(TW), .SETTLE(SETTLE)) dut (
      .CLK(CLK), .RSTX(RSTX), .START(START), .ABORT(ABORT), .CH_SEL(CH_SEL),
      .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT), .CH_RECV_CNT(CH_RECV_CNT),
      .CH_ERR_CNT(CH_ERR_CNT), .CH_CLR(CH_CLR), .BUSY(BUSY), .DONE(DONE),
      .ABORTED(ABORTED), .LIMIT_HIT(LIMIT_HIT), .RECV_CNT(RECV_CNT),
      .ERR_CNT(ERR_CNT), .ELAPSED(ELAPSED)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Counts seen by the edge numbered e are a known function of channel and e.
   function automatic logic [CW-1:0] recv_fn(input int ch, input int e);
      return (CW'(ch + 1) << 40) + CW'(3 * e + 5);
   endfunction
   function automatic logic [EW-1:0] err_fn(input int ch, input int e);
      return (EW'(ch + 1) << 48) + EW'(e);
   endfunction

   always @(negedge CLK)
      for (int i = 0; i < NCH; i++) begin
         CH_RECV_CNT[i*CW +: CW] = recv_fn(i, cyc + 1);
         CH_ERR_CNT[i*EW +: EW] = err_fn(i, cyc + 1);
      end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: scores every DONE/ABORTED pulse against the queued expectation.
   always @(negedge CLK) begin
      exp_t r;
      logic [NCH-1:0] pat;
      if (!RSTX) clr_cnt = 0;
      else begin
         if (CH_CLR != '1) begin
            clr_cnt++;
            clr_pat = CH_CLR;
         end
         if (DONE || ABORTED) begin
            if (q.size() == 0) chk("unexpected_pulse", {DONE, ABORTED}, 2'b00);
            else begin
               r = q.pop_front();
               pat = ~(NCH'(1) << r.ch);
               chk("pulse_cycle", cyc, r.cyc);
               chk("done", DONE, r.done);
               chk("aborted", ABORTED, r.aborted);
               chk("limit_hit", LIMIT_HIT, r.lh);
               chk("busy_at_end", BUSY, 0);
               chk("recv_cnt", RECV_CNT, r.recv);
               chk("err_cnt", ERR_CNT, r.err);
               chk("elapsed", ELAPSED, r.el);
               chk("measure_cycles", clr_cnt, r.done ? r.el : 0);
               if (r.done) chk("clr_pattern", clr_pat, pat);
            end
            clr_cnt = 0;
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   // mode 0 normal, 1 abort in CLEAR at clear cycle 'at', 2 abort at measure cycle 'at',
   // 3 START with ABORT in IDLE. lk>0 places ERR_LIMIT at the error count of measure cycle lk.
   task automatic run(input int ch, input int w, input int mode, input int at, input int lk);
      int t, wm, e, fin;
      logic [EW-1:0] lim;
      exp_t r;
      t = cyc + 1;
      wm = (w == 0) ? 1 : w;
      lim = (lk == 0) ? '0 : err_fn(ch, t + SETTLE + lk);
      START = 1; CH_SEL = CHW'(ch); WINDOW = TW'(w); ERR_LIMIT = lim; ABORT = (mode == 3);
      @(negedge CLK);
      START = 0; ABORT = 0;
      r.ch = ch; r.lh = 0;
      if (mode == 1) begin
         fin = 0;
         e = t + at;
         r.done = 0; r.aborted = 1;
         r.recv = snap_recv; r.err = snap_err; r.el = snap_el;
      end else begin
         fin = wm;
         if (mode == 2 && at < fin) fin = at;
`ifdef BER_EARLY_STOP_EN
         for (int k = 1; k <= fin; k++)
            if (lim != 0 && err_fn(ch, t + SETTLE + k) >= lim) begin
               fin = k;
               r.lh = 1;
               break;
            end
`endif
         e = t + SETTLE + fin;
         r.done = 1;
         r.aborted = (mode == 2 && at == fin);
         r.recv = recv_fn(ch, e); r.err = err_fn(ch, e); r.el = TW'(fin);
         snap_recv = r.recv; snap_err = r.err; snap_el = r.el;
      end
      r.cyc = e;
      q.push_back(r);
      if (mode != 1 && t + SETTLE / 2 < e - 1) begin
         wait_cyc(t + SETTLE / 2);
         START = 1; CH_SEL = CHW'((ch + 1) % NCH);
         @(negedge CLK);
         START = 0;
      end
      if (mode == 1 || (mode == 2 && at == fin)) begin
         wait_cyc(e - 1);
         ABORT = 1;
         @(negedge CLK);
         ABORT = 0;
      end
      wait_cyc(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int md, w, at, lk, g, t;
      logic [NCH-1:0] pat;
      #1 RSTX = 0;
      #1;
      chk("rst_ch_clr", CH_CLR, {NCH{1'b1}});
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_aborted", ABORTED, 0);
      chk("rst_limit_hit", LIMIT_HIT, 0);
      chk("rst_recv", RECV_CNT, 0);
      chk("rst_err", ERR_CNT, 0);
      chk("rst_elapsed", ELAPSED, 0);
      @(negedge CLK); @(negedge CLK);
      #2 RSTX = 1;
      @(negedge CLK);
      run(5, 100, 0, 0, 0);
      run(3, 0, 0, 0, 0);
      START = 1; CH_SEL = CHW'(7);
      @(negedge CLK);
      START = 0;
      for (int i = 0; i < 20; i++) begin
         chk("bad_ch_busy", BUSY, 0);
         @(negedge CLK);
      end
      run(1, 100, 2, 40, 0);
      run(6, 30, 1, 5, 0);
      run(0, 1000, 0, 0, 30);
      for (int n = 0; n < 40; n++) begin
         g = $urandom_range(0, 3);
         for (int j = 0; j < g; j++) begin
            START = ($urandom % 3 == 0);
            CH_SEL = CHW'(NCH + $urandom % (16 - NCH));
            ABORT = $urandom % 2;
            @(negedge CLK);
         end
         START = 0; ABORT = 0;
         md = $urandom % 10;
         md = (md < 5) ? 0 : (md < 7) ? 1 : (md < 9) ? 2 : 3;
         w = $urandom_range(0, 60);
         at = (md == 1) ? $urandom_range(1, SETTLE) : $urandom_range(1, ((w == 0) ? 1 : w) + 3);
         lk = ($urandom % 2) ? $urandom_range(1, w + 5) : 0;
         run($urandom % NCH, w, md, at, lk);
      end
      t = cyc + 1;
      START = 1; CH_SEL = CHW'(2); WINDOW = TW'(50); ERR_LIMIT = '0;
      @(negedge CLK);
      START = 0;
      wait_cyc(t + SETTLE + 10);
      pat = ~(NCH'(1) << 2);
      chk("pre_rst_clr", CH_CLR, pat);
      chk("pre_rst_busy", BUSY, 1);
      #2 RSTX = 0;
      #1;
      chk("mid_rst_ch_clr", CH_CLR, {NCH{1'b1}});
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_done", DONE, 0);
      chk("mid_rst_recv", RECV_CNT, 0);
      chk("mid_rst_err", ERR_CNT, 0);
      chk("mid_rst_elapsed", ELAPSED, 0);
      snap_recv = '0; snap_err = '0; snap_el = '0;
      @(negedge CLK);
      #2 RSTX = 1;
      @(negedge CLK);
      run(4, 12, 1, 3, 0);
      run(4, 12, 0, 0, 0);
      repeat (5) @(negedge CLK);
      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
